// File: rtl/sram_pkg.sv
// Shared types and constants for the parametrised SRAM behavioural model.
package sram_pkg;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_e;

    localparam int LANE_W       = 8;
    localparam int MAX_READ_LAT = 4;

    function automatic int lanes(input int data_w);
        return data_w / LANE_W;
    endfunction

endpackage

// File: rtl/sram_model_param_if.sv
// SRAM pin bundle; each side drives the shared DQ bus lane by lane through its own enables.
interface sram_model_param_if
    import sram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 18
);
    localparam int LANES = lanes(DATA_W);

    logic [ADDR_W-1:0] SRAM_ADDR;
    logic [LANES-1:0]  SRAM_BE_N;
    logic              SRAM_WE_N;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;
    logic [DATA_W-1:0] mst_dq;
    logic [LANES-1:0]  mst_oe;
    logic [DATA_W-1:0] dq_out;
    logic [LANES-1:0]  dq_oe;
    wire  [DATA_W-1:0] SRAM_DQ;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign SRAM_DQ[i*LANE_W +: LANE_W] = dq_oe[i]  ? dq_out[i*LANE_W +: LANE_W] : {LANE_W{1'bz}};
        assign SRAM_DQ[i*LANE_W +: LANE_W] = mst_oe[i] ? mst_dq[i*LANE_W +: LANE_W] : {LANE_W{1'bz}};
    end

    modport slave (
        input  SRAM_ADDR, SRAM_BE_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_DQ,
        output dq_out, dq_oe
    );

    modport master (
        output SRAM_ADDR, SRAM_BE_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, mst_dq, mst_oe,
        input  SRAM_DQ
    );

endinterface

// File: rtl/sram_rd_pipe.sv
// Fixed-latency read pipeline carrying {valid, data, lane mask}; only valids are reset.
module sram_rd_pipe #(
    parameter int DATA_W   = 16,
    parameter int LANES    = 2,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LANES-1:0]  in_mask,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [LANES-1:0]  out_mask
);

    logic [READ_LAT-1:0] valid_r;
    logic [DATA_W-1:0]   data_r [READ_LAT];
    logic [LANES-1:0]    mask_r [READ_LAT];

    // Valid shift chain, cleared asynchronously so a reset kills in-flight reads at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {READ_LAT{1'b0}};
        end else begin
            valid_r[0] <= in_valid;
            for (int i = 1; i < READ_LAT; i++) begin
                valid_r[i] <= valid_r[i-1];
            end
        end
    end

    // Payload shift chain; contents are meaningless without the matching valid.
    always_ff @(posedge clk) begin
        data_r[0] <= in_data;
        mask_r[0] <= in_mask;
        for (int i = 1; i < READ_LAT; i++) begin
            data_r[i] <= data_r[i-1];
            mask_r[i] <= mask_r[i-1];
        end
    end

    assign out_valid = valid_r[READ_LAT-1];
    assign out_data  = data_r[READ_LAT-1];
    assign out_mask  = mask_r[READ_LAT-1];

endmodule

// File: rtl/sram_model_param.sv
// Parametrised SRAM model: post-reset clear FSM, byte-lane writes, fixed-latency reads
// and per-lane tri-state drive onto the shared data bus.
module sram_model_param
    import sram_pkg::*;
#(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 18,
    parameter int                 DEPTH    = 64,
    parameter int                 READ_LAT = 1,
    parameter logic [DATA_W-1:0]  INIT_VAL = {DATA_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    sram_model_param_if.slave   bus,
    output logic                init_busy,
    output logic                addr_err
);

    localparam int                LANES    = lanes(DATA_W);
    localparam int                CNT_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    if (DATA_W % LANE_W != 0) begin : g_bad_data_w
        $fatal(1, "sram_model_param: DATA_W must be a multiple of 8");
    end
    if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : g_bad_read_lat
        $fatal(1, "sram_model_param: READ_LAT must be in 1..4");
    end
    if (DEPTH < 2 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $fatal(1, "sram_model_param: DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_W");
    end

    state_e             state_r;
    state_e             state_n;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_n;
    logic               addr_err_r;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               access_s;
    logic               in_range_s;
    logic [CNT_W-1:0]   idx_s;
    logic [DATA_W-1:0]  rd_data_s;
    logic               mem_we_s;
    logic [CNT_W-1:0]   mem_idx_s;
    logic [DATA_W-1:0]  mem_wdata_s;
    logic [LANES-1:0]   mem_wmask_s;
    logic               pipe_valid_s;
    logic [DATA_W-1:0]  pipe_data_s;
    logic [LANES-1:0]   pipe_mask_s;

    assign access_s   = (state_r == S_READY) && !bus.SRAM_CE_N;
    assign in_range_s = ({1'b0, bus.SRAM_ADDR} < DEPTH_L);
    assign idx_s      = bus.SRAM_ADDR[CNT_W-1:0];
    // Out-of-range reads return zeros rather than whatever the truncated index aliases to.
    assign rd_data_s  = in_range_s ? mem[idx_s] : {DATA_W{1'b0}};

    // Clear FSM next-state: walk the counter once over the array, then stay ready.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        case (state_r)
            S_CLEAR: begin
                if (cnt_r == LAST_IDX) begin
                    state_n = S_READY;
                    cnt_n   = {CNT_W{1'b0}};
                end else begin
                    cnt_n   = cnt_r + CNT_ONE;
                end
            end
            S_READY: begin
                state_n = S_READY;
            end
            default: begin
                state_n = S_CLEAR;
                cnt_n   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and the one-cycle out-of-range flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_CLEAR;
            cnt_r      <= {CNT_W{1'b0}};
            addr_err_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            addr_err_r <= access_s && !in_range_s;
        end
    end

    // Single write port shared by the clear sweep and bus writes.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_idx_s   = cnt_r;
        mem_wdata_s = INIT_VAL;
        mem_wmask_s = {LANES{1'b1}};
        if (state_r == S_CLEAR) begin
            mem_we_s    = 1'b1;
        end else if (access_s && !bus.SRAM_WE_N && in_range_s) begin
            mem_we_s    = 1'b1;
            mem_idx_s   = idx_s;
            mem_wdata_s = bus.SRAM_DQ;
            mem_wmask_s = ~bus.SRAM_BE_N;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Array update, one byte lane at a time.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (mem_we_s && mem_wmask_s[i]) begin
                mem[mem_idx_s][i*LANE_W +: LANE_W] <= mem_wdata_s[i*LANE_W +: LANE_W];
            end
        end
    end

    sram_rd_pipe #(
        .DATA_W   (DATA_W),
        .LANES    (LANES),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (access_s && bus.SRAM_WE_N),
        .in_data   (rd_data_s),
        .in_mask   (~bus.SRAM_BE_N),
        .out_valid (pipe_valid_s),
        .out_data  (pipe_data_s),
        .out_mask  (pipe_mask_s)
    );

    // Lane drive enables; WE_N low always releases the bus so master write data never contends.
    always_comb begin
        bus.dq_oe = {LANES{1'b0}};
        if (pipe_valid_s && !bus.SRAM_OE_N && bus.SRAM_WE_N && !bus.SRAM_CE_N) begin
            bus.dq_oe = pipe_mask_s;
        end else begin
            bus.dq_oe = {LANES{1'b0}};
        end
    end

    assign bus.dq_out = pipe_data_s;
    assign init_busy  = (state_r == S_CLEAR);
    assign addr_err   = addr_err_r;

endmodule

// File: doc/sram_model_param.md
Name: sram_model_param

Overview:
Parametrised behavioural model of the external asynchronous-style SRAM used by the processor's memory stage. It generalises the fixed 16-bit, 64-word model in the following ways:
- data width and depth are parameters
- byte lanes are per-lane
- read latency is configurable
- chip-enable and output-enable are fully honoured
- an out-of-range address flag is provided
- after reset, a self-clearing state machine zeroes the array one word per cycle
It sits on the testbench side of the SRAM controller and drives/receives the bidirectional data bus.

Parameters:
DATA_W, 16, data bus width; must be a multiple of 8.
ADDR_W, 18, address bus width.
DEPTH, 64, number of implemented words; must satisfy 2 <= DEPTH <= 2**ADDR_W.
READ_LAT, 1, clocks from read issue to data on the bus; must be between 1 and 4.
INIT_VAL, 0, DATA_W-bit value written to every word during the clear phase.
LANES, DATA_W/8, derived localparam (not overridable).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
SRAM_DQ  inout  DATA_W  bidirectional data bus.
SRAM_ADDR  in  ADDR_W  word address.
SRAM_BE_N  in  LANES  active-low byte-lane enables; bit i covers DQ[8i+7:8i].
SRAM_WE_N  in  1  active-low write enable.
SRAM_CE_N  in  1  active-low chip enable.
SRAM_OE_N  in  1  active-low output enable.
init_busy  out  1  high while the clear FSM is running.
addr_err  out  1  one-cycle pulse when an access uses SRAM_ADDR >= DEPTH.

Behaviour:
- Reset (asynchronous):
  - FSM goes to S_CLEAR; clear counter = 0.
  - init_busy = 1, addr_err = 0.
  - All read-pipeline valid bits = 0.
  - SRAM_DQ = all Z, taking effect immediately rather than at the next edge.
- S_CLEAR:
  - Each rising edge writes INIT_VAL to memory[cnt], then cnt increments.
  - After the edge that writes word DEPTH-1, the FSM moves to S_READY and init_busy falls.
  - init_busy is therefore high for exactly DEPTH edges after rst deasserts.
  - All bus accesses are ignored; addr_err stays 0.
- A rst assertion mid-clear restarts the clear from word 0.
- S_READY access qualification (sampled at posedge): access = !CE_N.
- Write (access and !WE_N):
  - Each lane i with BE_N[i]=0 takes DQ lane i into memory[ADDR].
  - Lanes with BE_N[i]=1 are unchanged.
  - OE_N is ignored for writes.
- Read issue (access and WE_N):
  - Pipeline stage 1 captures the valid bit, memory[ADDR] as it stood before this edge, and the lane mask ~BE_N.
  - Stages shift by one each clock; the output stage is stage READ_LAT.
  - An in-flight read is unaffected by later writes to the same address.
  - A read issued on the edge after a write to the same address returns the new data.
- Bus drive (combinational from registered state):
  - Lane i of DQ = output-stage data lane i when all of these hold: output-stage valid, lane mask bit i set, OE_N=0, WE_N=1, CE_N=0.
  - Otherwise lane i = Z.
  - WE_N low therefore always releases the bus, giving no contention with master write data.
- Out of range (ADDR >= DEPTH) with access:
  - A write is discarded.
  - A read returns all zeros on its enabled lanes.
  - addr_err is registered high for exactly the following cycle.
- Idle (CE_N=1): no memory change; a bubble (valid=0) enters the pipeline.
- Back-to-back reads: one per cycle, full throughput, latency fixed at READ_LAT.
- rst during in-flight reads: all valids clear and DQ goes Z at once.
- Simulation-only parameter checks: DATA_W%8 != 0, READ_LAT outside 1..4, or DEPTH > 2**ADDR_W each print a fatal error at time 0.

Decomposition:
- Package sram_pkg:
  - state enum {S_CLEAR, S_READY}
  - LANE_W = 8
  - function lanes(DATA_W)
  - MAX_READ_LAT = 4
- Sub-module sram_rd_pipe, parametrised by DATA_W, LANES and READ_LAT:
  - a READ_LAT-deep shift register of {valid, data, lane_mask}
  - asynchronous reset clears every valid bit
- Top level holds: memory array, clear FSM/counter, write logic, range check, tri-state drive.

Test Plan:
- Default params, pulse rst for 2 cycles:
  - init_busy stays high for 64 edges, then falls.
  - Reading any address 0..63 returns 16'h0000.
  - DQ is Z throughout the clear.
- Write 16'hBEEF to addr 5 with BE_N=2'b00, then read addr 5 with OE_N=0, READ_LAT=1:
  - DQ = 16'hBEEF exactly one edge after issue.
  - DQ returns to Z when OE_N goes high.
- Byte-lane mask:
  - Write 16'h1234 to addr 7 with BE_N=2'b00, then write 16'hAB00 with BE_N=2'b01 (upper lane only).
  - Read with BE_N=2'b00 returns 16'hAB34.
  - Read with BE_N=2'b10 drives only DQ[7:0]=8'h34; DQ[15:8] = Z.
- READ_LAT=3, reads back to back of addr 1,2,3 holding 16'h0011/16'h0022/16'h0033:
  - Values appear on consecutive cycles starting 3 edges after the first issue.
  - A write of 16'hFFFF to addr 2 one cycle after its read still yields 16'h0022.
- Out of range: write 16'h5555 to addr 64, then read addr 64:
  - addr_err pulses for 1 cycle after each access.
  - The read returns 16'h0000; words 0..63 are unchanged.
- Reset mid-operation:
  - Assert rst with a read in flight (READ_LAT=2) and during the clear at cnt=30.
  - DQ goes Z immediately.
  - After release, init_busy is high for a full 64 edges.
  - The in-flight data never appears on the bus.
